// File: rtl/ref_window_shifter_if.sv
// ref_window_shifter_if
//   Stream bundle for the reference window shifter: an input beat stream of
//   LANES pixels and an output stream of full DEPTH-pixel windows, each with
//   its own valid/ready handshake.
//   Signals:
//     in_valid / in_ready / in_data      producer -> shifter beat stream
//     win_valid / win_ready / win_data   shifter -> consumer window stream
//   Modports:
//     slave  - the shifter's view (takes beats, offers windows)
//     master - the environment's view (offers beats, takes windows)
interface ref_window_shifter_if #(
  parameter int PIXEL_W = 8,
  parameter int LANES   = 4,
  parameter int DEPTH   = 16
);

  logic                       in_valid;
  logic                       in_ready;
  logic [LANES*PIXEL_W-1:0]   in_data;
  logic                       win_valid;
  logic                       win_ready;
  logic [DEPTH*PIXEL_W-1:0]   win_data;

  modport slave (
    input  in_valid,
    output in_ready,
    input  in_data,
    output win_valid,
    input  win_ready,
    output win_data
  );

  modport master (
    output in_valid,
    input  in_ready,
    output in_data,
    input  win_valid,
    output win_ready,
    input  win_data
  );

endinterface

// File: rtl/ref_window_shifter.sv
// ref_window_shifter
//   Multi-lane sliding-window shift register feeding the SAD/interpolation
//   datapath. Each accepted beat shifts LANES new pixels into a DEPTH-pixel
//   window, either at the LSB end (dir=0, shift left) or at the MSB end
//   (dir=1, shift right). Once DEPTH/LANES beats are held, every window
//   position is presented exactly once on the win_* handshake.
//   Ports:
//     clk         rising-edge clock
//     reset       synchronous active-high reset (highest priority)
//     clear       synchronous flush of window, fill and window count
//     dir         per-beat shift direction (0 left, 1 right)
//     bus         ref_window_shifter_if.slave (beat in, window out)
//     fill_count  beats held, saturating at DEPTH/LANES
//     win_count   windows handed over since reset/clear, wrapping
module ref_window_shifter #(
  parameter int PIXEL_W = 8,
  parameter int LANES   = 4,
  parameter int DEPTH   = 16,
  parameter int CNT_W   = 16,
  localparam int BEATS  = DEPTH / LANES,
  localparam int FILL_W = $clog2(BEATS + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     dir,
  ref_window_shifter_if.slave      bus,
  output logic [FILL_W-1:0]        fill_count,
  output logic [CNT_W-1:0]         win_count
);

  localparam int BEAT_W = LANES * PIXEL_W;
  localparam int WIN_W  = DEPTH * PIXEL_W;

  logic [WIN_W-1:0]  win_q;
  logic              pending;
  logic              accept;
  logic              take;
  logic [WIN_W-1:0]  in_ext;
  logic [WIN_W-1:0]  win_shifted;
  logic [FILL_W-1:0] fill_next;

  // The only stall is a full window the consumer has not taken yet; a
  // consumer taking it this cycle frees the slot for the next beat, which
  // gives one window per cycle at full rate. clear blocks acceptance so the
  // flush cannot be half-undone by a beat arriving the same cycle.
  always_comb begin
    bus.in_ready = !clear && !(pending && !bus.win_ready);
    accept       = bus.in_valid && bus.in_ready;
    take         = pending && bus.win_ready;
    bus.win_valid = pending;
    bus.win_data  = win_q;
  end

  // Builds the slid window for an accepted beat. The new lanes are
  // zero-extended to window width and shifted into place, which stays legal
  // when DEPTH == LANES (the old window is then shifted out completely).
  always_comb begin
    in_ext      = WIN_W'(bus.in_data);
    win_shifted = win_q;
    if (!dir) begin
      win_shifted = (win_q << BEAT_W) | in_ext;
    end else begin
      win_shifted = (win_q >> BEAT_W) | (in_ext << (WIN_W - BEAT_W));
    end
    if (fill_count == FILL_W'(BEATS)) begin
      fill_next = fill_count;
    end else begin
      fill_next = fill_count + 1'b1;
    end
  end

  // Window, fill and handshake state. A beat accepted while the window is
  // already full re-arms pending, so a simultaneous consume + beat counts
  // the old window and immediately presents the new one.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      win_q      <= '0;
      fill_count <= '0;
      pending    <= 1'b0;
      win_count  <= '0;
    end else begin
      if (accept) begin
        win_q      <= win_shifted;
        fill_count <= fill_next;
        pending    <= (fill_next == FILL_W'(BEATS));
      end else if (take) begin
        pending <= 1'b0;
      end
      if (take) begin
        win_count <= win_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ref_window_shifter.sv
// tb_ref_window_shifter
//   Directed bench for ref_window_shifter with PIXEL_W=8, LANES=2, DEPTH=8
//   (four beats per window). Each task drives one scenario and compares the
//   outputs against hand-computed values.
module tb_ref_window_shifter;

  localparam int PIXEL_W = 8;
  localparam int LANES   = 2;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 16;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        dir;
  logic [2:0]  fill_count;
  logic [15:0] win_count;

  int n_compared;
  int n_mismatched;

  ref_window_shifter_if #(.PIXEL_W(PIXEL_W), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  ref_window_shifter #(
    .PIXEL_W(PIXEL_W),
    .LANES  (LANES),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .dir       (dir),
    .bus       (bus),
    .fill_count(fill_count),
    .win_count (win_count)
  );

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advances one clock edge and settles 1 unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1111;
    tick();
    tick();
    n_compared++;
    if (bus.win_data !== 64'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_win_data: got %h expected %h", bus.win_data, 64'h0);
    end
    n_compared++;
    if (fill_count !== 3'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_fill: got %0d expected 0", fill_count);
    end
    n_compared++;
    if (bus.win_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_win_valid: got %b expected 0", bus.win_valid);
    end
    n_compared++;
    if (win_count !== 16'd0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_win_count: got %0d expected 0", win_count);
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    n_compared++;
    if (fill_count !== 3'd0 || bus.win_data !== 64'h0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_no_accept: got fill %0d data %h expected fill 0 data 0",
               fill_count, bus.win_data);
    end
  endtask

  task automatic test_fill_left();
    logic [15:0] beats [4];
    beats[0] = 16'h0201; beats[1] = 16'h0403; beats[2] = 16'h0605; beats[3] = 16'h0807;
    dir = 1'b0;
    bus.win_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beats[i];
      tick();
      if (i == 2) begin
        n_compared++;
        if (bus.win_valid !== 1'b0 || fill_count !== 3'd3) begin
          n_mismatched++;
          $display("[TB] FAIL left_three_beats: got valid %b fill %0d expected valid 0 fill 3",
                   bus.win_valid, fill_count);
        end
      end
    end
    bus.in_valid = 1'b0;
    #1;
    n_compared++;
    if (bus.win_data !== 64'h0201040306050807) begin
      n_mismatched++;
      $display("[TB] FAIL left_win_data: got %h expected %h", bus.win_data, 64'h0201040306050807);
    end
    n_compared++;
    if (fill_count !== 3'd4 || bus.win_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL left_flags: got fill %0d valid %b ready %b expected fill 4 valid 1 ready 0",
               fill_count, bus.win_valid, bus.in_ready);
    end
  endtask

  task automatic test_stall_consume();
    bus.win_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'hEEEE;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_compared++;
      if (bus.win_data !== 64'h0201040306050807 || bus.win_valid !== 1'b1 ||
          bus.in_ready !== 1'b0 || fill_count !== 3'd4) begin
        n_mismatched++;
        $display("[TB] FAIL stall_hold: got data %h valid %b ready %b fill %0d expected data %h valid 1 ready 0 fill 4",
                 bus.win_data, bus.win_valid, bus.in_ready, fill_count, 64'h0201040306050807);
      end
    end
    bus.win_ready = 1'b1;
    bus.in_data   = 16'h0A09;
    #1;
    n_compared++;
    if (bus.in_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL stall_release_ready: got %b expected 1", bus.in_ready);
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.win_ready = 1'b0;
    #1;
    n_compared++;
    if (bus.win_data !== 64'h0403060508070A09) begin
      n_mismatched++;
      $display("[TB] FAIL slide_win_data: got %h expected %h", bus.win_data, 64'h0403060508070A09);
    end
    n_compared++;
    if (bus.win_valid !== 1'b1 || win_count !== 16'd1) begin
      n_mismatched++;
      $display("[TB] FAIL slide_flags: got valid %b count %0d expected valid 1 count 1",
               bus.win_valid, win_count);
    end
    bus.win_ready = 1'b1;
    tick();
    bus.win_ready = 1'b0;
    #1;
    n_compared++;
    if (bus.win_valid !== 1'b0 || win_count !== 16'd2 || fill_count !== 3'd4) begin
      n_mismatched++;
      $display("[TB] FAIL consume_only: got valid %b count %0d fill %0d expected valid 0 count 2 fill 4",
               bus.win_valid, win_count, fill_count);
    end
  endtask

  task automatic test_fill_right();
    logic [15:0] beats [4];
    beats[0] = 16'h0201; beats[1] = 16'h0403; beats[2] = 16'h0605; beats[3] = 16'h0807;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_compared++;
    if (win_count !== 16'd0 || fill_count !== 3'd0 || bus.win_data !== 64'h0) begin
      n_mismatched++;
      $display("[TB] FAIL clear_state: got count %0d fill %0d data %h expected all zero",
               win_count, fill_count, bus.win_data);
    end
    dir = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beats[i];
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    n_compared++;
    if (bus.win_data !== 64'h0807060504030201 || bus.win_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL right_win_data: got %h valid %b expected %h valid 1",
               bus.win_data, bus.win_valid, 64'h0807060504030201);
    end
  endtask

  task automatic test_clear_midfill();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    dir = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h1211;
    tick();
    bus.in_data  = 16'h1413;
    tick();
    clear = 1'b1;
    bus.in_data = 16'h1615;
    #1;
    n_compared++;
    if (bus.in_ready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL clear_in_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    n_compared++;
    if (bus.win_data !== 64'h0 || fill_count !== 3'd0 || bus.win_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL clear_midfill: got data %h fill %0d valid %b expected 0 0 0",
               bus.win_data, fill_count, bus.win_valid);
    end
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'(16'h2221 + i * 16'h0202);
      tick();
      if (i == 2) begin
        n_compared++;
        if (bus.win_valid !== 1'b0 || fill_count !== 3'd3) begin
          n_mismatched++;
          $display("[TB] FAIL refill_three: got valid %b fill %0d expected valid 0 fill 3",
                   bus.win_valid, fill_count);
        end
      end
    end
    bus.in_valid = 1'b0;
    #1;
    n_compared++;
    if (bus.win_valid !== 1'b1 || bus.win_data !== 64'h2221242326252827) begin
      n_mismatched++;
      $display("[TB] FAIL refill_four: got valid %b data %h expected valid 1 data %h",
               bus.win_valid, bus.win_data, 64'h2221242326252827);
    end
  endtask

  task automatic test_back_to_back();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    dir = 1'b0;
    bus.win_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = {8'(2 * k + 2), 8'(2 * k + 1)};
      #1;
      n_compared++;
      if (bus.in_ready !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL full_rate_ready beat %0d: got %b expected 1", k, bus.in_ready);
      end
      tick();
      n_compared++;
      if (bus.win_valid !== (k >= 3)) begin
        n_mismatched++;
        $display("[TB] FAIL full_rate_valid beat %0d: got %b expected %b", k, bus.win_valid, (k >= 3));
      end
    end
    bus.in_valid = 1'b0;
    n_compared++;
    if (bus.win_data !== 64'h0E0D100F12111413) begin
      n_mismatched++;
      $display("[TB] FAIL full_rate_data: got %h expected %h", bus.win_data, 64'h0E0D100F12111413);
    end
    tick();
    bus.win_ready = 1'b0;
    #1;
    n_compared++;
    if (win_count !== 16'd7 || bus.win_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL full_rate_drain: got count %0d valid %b expected count 7 valid 0",
               win_count, bus.win_valid);
    end
  endtask

  initial begin
    n_compared    = 0;
    n_mismatched  = 0;
    reset         = 1'b1;
    clear         = 1'b0;
    dir           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.win_ready = 1'b0;
    test_reset();
    test_fill_left();
    test_stall_consume();
    test_fill_right();
    test_clear_midfill();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
